// File: rtl/mem_bus_interconnect.sv
// Single-master to NUM_SLV-slave memory interconnect with address-window decode,
// wait-state handshake, slave timeout and fault capture.
//
// state  | meaning
// IDLE   | decode m_req, latch request fields
// ACCESS | s_en asserted to selected slave, waiting for s_ack or timeout
// RESP   | one-cycle m_ready with captured read data
// ERR    | one-cycle m_ready+m_err, fault counter bumps
module mem_bus_interconnect #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int PHY_W   = 13,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h10030000, 32'h10020000, 32'h10010000, 32'h10000000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hFFFFE000}},
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_req,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W/8-1:0]       m_we,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic                      m_ready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [NUM_SLV-1:0]        s_en,
  output logic [PHY_W-1:0]          s_addr,
  output logic [DATA_W/8-1:0]       s_we,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ack,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [SEL_W-1:0]    sel_q;
  logic [7:0]          timer_q;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic                timer_done;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign ack_sel    = s_ack[sel_q];
  assign rdata_sel  = s_rdata[int'(sel_q)*DATA_W +: DATA_W];
  assign timer_done = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_req) state_d = hit ? ACCESS : ERR;
      ACCESS: begin
        if (ack_sel)         state_d = RESP;
        else if (timer_done) state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      timer_q  <= '0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_req && hit) begin
            addr_q  <= m_addr;
            we_q    <= m_we;
            wdata_q <= m_wdata;
            sel_q   <= hit_idx;
            timer_q <= '0;
          end else if (m_req) begin
            err_addr <= m_addr;
          end
        end
        ACCESS: begin
          timer_q <= timer_q + 8'd1;
          if (ack_sel)         rdata_q  <= rdata_sel;
          else if (timer_done) err_addr <= addr_q;
        end
        ERR: if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign m_ready = (state_q == RESP) || (state_q == ERR);
  assign m_err   = (state_q == ERR);
  assign m_rdata = (state_q == RESP) ? rdata_q : '0;
  assign s_en    = (state_q == ACCESS) ? (NUM_SLV'(1) << sel_q) : '0;
  assign s_addr  = addr_q[PHY_W-1:0];
  assign s_we    = we_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Directed bench for mem_bus_interconnect: reads, waited writes, misses,
// timeout, overlapping windows, error saturation and async reset.
module tb_mem_bus_interconnect;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic [31:0]  m_addr;
  logic [3:0]   m_we;
  logic [31:0]  m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_en;
  logic [12:0]  s_addr;
  logic [3:0]   s_we;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  int errors = 0;
  int checks = 0;

  // Slave 3 gets a wide window that overlaps slaves 0..2.
  mem_bus_interconnect #(
    .SLV_MASK({32'hFFF00000, {3{32'hFFFFE000}}})
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_en(s_en), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat, en_cycles, pulses;
    rst = 1'b0; m_req = 1'b0; m_addr = '0; m_we = '0; m_wdata = '0;
    s_rdata = '0; s_ack = '0;
    #1;
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_en", s_en, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_m_rdata", m_rdata, 0);
    @(negedge clk); rst = 1'b1;

    // 1: zero-wait read from slave 1
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h10010008; m_we = 4'b0000;
    s_rdata[32 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_s_en", s_en, 4'b0010);
    chk("t1_s_addr", s_addr, 13'h0008);
    chk("t1_ready_early", m_ready, 0);
    s_ack = 4'b0010;
    @(negedge clk);
    chk("t1_m_ready", m_ready, 1);
    chk("t1_m_err", m_err, 0);
    chk("t1_m_rdata", m_rdata, 32'hDEADBEEF);
    chk("t1_s_en_off", s_en, 0);
    m_req = 1'b0; s_ack = '0;
    @(negedge clk);
    chk("t1_ready_drop", m_ready, 0);

    // 2: byte write to slave 0 with 3 wait states; master fields change mid-access
    m_req = 1'b1; m_addr = 32'h10000004; m_we = 4'b0100; m_wdata = 32'h00AB0000;
    s_rdata[0 +: 32] = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_s_en", s_en, 4'b0001);
      chk("t2_s_we", s_we, 4'b0100);
      chk("t2_s_wdata", s_wdata, 32'h00AB0000);
      chk("t2_s_addr", s_addr, 13'h0004);
      chk("t2_wait_ready", m_ready, 0);
      m_wdata = 32'hFFFFFFFF; m_we = 4'hF; m_addr = 32'h10010000;
      s_ack = (i == 3) ? 4'b0001 : 4'b0010;
    end
    @(negedge clk);
    chk("t2_m_ready", m_ready, 1);
    chk("t2_m_err", m_err, 0);
    chk("t2_m_rdata", m_rdata, 32'h11223344);
    chk("t2_err_cnt", err_cnt, 0);
    m_req = 1'b0; s_ack = '0; m_we = '0;

    // 3: unmapped address
    @(negedge clk);
    chk("t3_idle_ready", m_ready, 0);
    m_req = 1'b1; m_addr = 32'h00000010;
    @(negedge clk);
    chk("t3_m_ready", m_ready, 1);
    chk("t3_m_err", m_err, 1);
    chk("t3_m_rdata", m_rdata, 0);
    chk("t3_s_en", s_en, 0);
    chk("t3_err_addr", err_addr, 32'h00000010);
    m_req = 1'b0;
    @(negedge clk);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_ready_drop", m_ready, 0);

    // 4: slave 2 never acks -> timeout
    m_req = 1'b1; m_addr = 32'h10020000;
    lat = 0; en_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (m_ready) break;
      if (s_en == 4'b0100) en_cycles++;
    end
    chk("t4_latency", lat, 16);
    chk("t4_en_cycles", en_cycles, 15);
    chk("t4_m_err", m_err, 1);
    chk("t4_err_addr", err_addr, 32'h10020000);
    s_ack = 4'b0100; m_req = 1'b0;
    @(negedge clk);
    chk("t4_late_ack_ready", m_ready, 0);
    chk("t4_late_ack_s_en", s_en, 0);
    chk("t4_err_cnt", err_cnt, 2);
    s_ack = '0;

    // 5: overlapping windows resolve to lowest index; slave 3 reachable alone
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h10000020;
    @(negedge clk);
    chk("t5_overlap_s_en", s_en, 4'b0001);
    s_ack = 4'b0001;
    @(negedge clk);
    chk("t5_overlap_ready", m_ready, 1);
    m_req = 1'b0; s_ack = '0;
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h10050000; s_rdata[96 +: 32] = 32'hCAFEF00D;
    @(negedge clk);
    chk("t5_slv3_s_en", s_en, 4'b1000);
    s_ack = 4'b1000;
    @(negedge clk);
    chk("t5_slv3_rdata", m_rdata, 32'hCAFEF00D);
    m_req = 1'b0; s_ack = '0;

    // 5b: 256 consecutive misses saturate the fault counter
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h00000010;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (m_err) pulses++;
      if (i == 255) m_req = 1'b0;
      @(negedge clk);
      if (i == 100) chk("t5_err_cnt_mid", err_cnt, 103);
    end
    chk("t5_miss_pulses", pulses, 256);
    chk("t5_err_cnt_sat", err_cnt, 255);
    chk("t5_idle_ready", m_ready, 0);

    // 6: async reset during ACCESS, then a clean read
    m_req = 1'b1; m_addr = 32'h10010010; s_rdata[32 +: 32] = 32'h0BADC0DE;
    @(negedge clk);
    chk("t6_s_en_pre", s_en, 4'b0010);
    #2 rst = 1'b0; m_req = 1'b0;
    #1;
    chk("t6_rst_s_en", s_en, 0);
    chk("t6_rst_m_ready", m_ready, 0);
    chk("t6_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    chk("t6_hold_ready", m_ready, 0);
    rst = 1'b1; m_req = 1'b1; m_addr = 32'h10010010;
    @(negedge clk);
    chk("t6_s_en", s_en, 4'b0010);
    chk("t6_s_addr", s_addr, 13'h0010);
    @(negedge clk);
    chk("t6_wait_ready", m_ready, 0);
    s_ack = 4'b0010;
    @(negedge clk);
    chk("t6_m_ready", m_ready, 1);
    chk("t6_m_rdata", m_rdata, 32'h0BADC0DE);
    chk("t6_m_err", m_err, 0);
    m_req = 1'b0; s_ack = '0;
    @(negedge clk);
    chk("t6_ready_drop", m_ready, 0);
    chk("t6_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
